// File: rtl/vga_pkg.sv
// Shared VGA defaults and frame-buffer types.
package vga_pkg;

    localparam int VGA_COLS      = 640;
    localparam int VGA_ROWS      = 480;
    localparam int VGA_H_BITS    = 10;
    localparam int VGA_V_BITS    = 9;
    localparam int CLIP_CNT_BITS = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } vga_buf_state_t;

endpackage

// File: rtl/vga_frame_buffer_bram.sv
// Simple dual-port block RAM: one write port, one registered read port (read-first).
module vga_frame_buffer_bram #(
    parameter int    ROWS      = 16,
    parameter int    COLS      = 8,
    parameter int    ADDR_BITS = 4,
    parameter string INIT_FILE = ""
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [COLS-1:0]      wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [COLS-1:0]      rdata_o
);

    logic [COLS-1:0] mem_q [ROWS];
    logic [COLS-1:0] rdata_q;

    // The image name is carried for the vendor memory-init flow; RTL does not preload it.
    localparam bit HAS_INIT_IMAGE = (INIT_FILE != "");
    logic init_image_unused;
    assign init_image_unused = HAS_INIT_IMAGE;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_frame_buffer.sv
// Pixel frame buffer: handshake write port, continuous 1-cycle read port, full-frame clear.
// Optional clip counter enabled by defining VGA_BUF_CLIP_CNT_EN.
module vga_frame_buffer
    import vga_pkg::*;
#(
    parameter int                    PIXEL_BITS = 8,
    parameter int                    COLS       = VGA_COLS,
    parameter int                    ROWS       = VGA_ROWS,
    parameter int                    X_BITS     = VGA_H_BITS,
    parameter int                    Y_BITS     = VGA_V_BITS,
    parameter logic [PIXEL_BITS-1:0] OOB_VALUE  = '0,
    parameter string                 INIT_FILE  = "data/vga_buf_init.mem"
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [X_BITS-1:0]        rd_x,
    input  logic [Y_BITS-1:0]        rd_y,
    output logic [PIXEL_BITS-1:0]    rd_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [X_BITS-1:0]        wr_x,
    input  logic [Y_BITS-1:0]        wr_y,
    input  logic [PIXEL_BITS-1:0]    wr_data,
    input  logic                     clear_start,
    input  logic [PIXEL_BITS-1:0]    clear_color,
    output logic                     busy,
    output logic                     clear_done,
    output logic [CLIP_CNT_BITS-1:0] clip_cnt
);

    localparam int DEPTH     = COLS * ROWS;
    localparam int ADDR_BITS = $clog2(DEPTH);
    localparam int WIDE_BITS = ADDR_BITS + 1;

    vga_buf_state_t        state_q, state_d;
    logic [ADDR_BITS-1:0]  clr_addr_q, clr_addr_d;
    logic [PIXEL_BITS-1:0] clr_color_q, clr_color_d;
    logic                  rd_oob_q, rd_live_q;

    logic                  wr_in_range, rd_in_range;
    logic [WIDE_BITS-1:0]  wr_addr_wide, rd_addr_wide;
    logic                  ram_we;
    logic [ADDR_BITS-1:0]  ram_waddr;
    logic [PIXEL_BITS-1:0] ram_wdata, ram_rdata;
    logic                  clr_last;

    // Address is formed one bit wider than the RAM so an off-frame product is never aliased.
    assign wr_addr_wide = WIDE_BITS'(wr_y) * WIDE_BITS'(COLS) + WIDE_BITS'(wr_x);
    assign rd_addr_wide = WIDE_BITS'(rd_y) * WIDE_BITS'(COLS) + WIDE_BITS'(rd_x);
    assign wr_in_range  = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
    assign rd_in_range  = (32'(rd_x) < COLS) && (32'(rd_y) < ROWS);
    assign clr_last     = (clr_addr_q == ADDR_BITS'(DEPTH - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            clr_color_q <= clr_color_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        clr_color_d = clr_color_q;
        wr_ready    = 1'b0;
        busy        = 1'b0;
        clear_done  = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = wr_addr_wide[ADDR_BITS-1:0];
        ram_wdata   = wr_data;
        case (state_q)
            IDLE: begin
                wr_ready = ~clear_start;
                if (clear_start) begin
                    state_d     = CLEAR;
                    clr_addr_d  = '0;
                    clr_color_d = clear_color;
                end else if (wr_valid && wr_in_range) begin
                    ram_we = 1'b1;
                end
            end
            CLEAR: begin
                busy       = 1'b1;
                ram_we     = 1'b1;
                ram_waddr  = clr_addr_q;
                ram_wdata  = clr_color_q;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_last) begin
                    clear_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    vga_frame_buffer_bram #(
        .ROWS      (DEPTH),
        .COLS      (PIXEL_BITS),
        .ADDR_BITS (ADDR_BITS),
        .INIT_FILE (INIT_FILE)
    ) u_bram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr_wide[ADDR_BITS-1:0]),
        .rdata_o (ram_rdata)
    );

    // RAM output has no reset, so a live flag forces 0 until the first post-reset read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_oob_q  <= 1'b0;
            rd_live_q <= 1'b0;
        end else begin
            rd_oob_q  <= ~rd_in_range;
            rd_live_q <= 1'b1;
        end
    end

    assign rd_data = !rd_live_q ? '0 : (rd_oob_q ? OOB_VALUE : ram_rdata);

`ifdef VGA_BUF_CLIP_CNT_EN
    logic [CLIP_CNT_BITS-1:0] clip_cnt_q, clip_cnt_d;
    logic                     wr_accept;

    assign wr_accept = wr_valid & wr_ready;

    always_comb begin
        clip_cnt_d = clip_cnt_q;
        if (wr_accept && !wr_in_range && (clip_cnt_q != '1)) begin
            clip_cnt_d = clip_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clip_cnt_q <= '0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
        end
    end

    assign clip_cnt = clip_cnt_q;
`else
    assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Self-checking bench for vga_frame_buffer (4x3 frame) with a read scoreboard and a pixel model.
module tb_vga_frame_buffer;

    localparam logic [7:0] OOB = 8'h3C;
`ifdef VGA_BUF_CLIP_CNT_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  rd_x = '0;
    logic [1:0]  rd_y = '0;
    logic [7:0]  rd_data;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [2:0]  wr_x = '0;
    logic [1:0]  wr_y = '0;
    logic [7:0]  wr_data = '0;
    logic        clear_start = 1'b0;
    logic [7:0]  clear_color = '0;
    logic        busy;
    logic        clear_done;
    logic [15:0] clip_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  model[12];
    logic [15:0] exp_clip = '0;

    vga_frame_buffer #(
        .PIXEL_BITS (8),
        .COLS       (4),
        .ROWS       (3),
        .X_BITS     (3),
        .Y_BITS     (2),
        .OOB_VALUE  (OOB),
        .INIT_FILE  ("")
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_data     (rd_data),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_data     (wr_data),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .busy        (busy),
        .clear_done  (clear_done),
        .clip_cnt    (clip_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive read coordinates and queue the value the frame should return one edge later.
    task automatic issue_read(input int x, input int y);
        rd_x = 3'(x);
        rd_y = 2'(y);
        if (x < 4 && y < 3) sb_q.push_back(model[y * 4 + x]);
        else                sb_q.push_back(OOB);
    endtask

    // Drives a clear whose clear_start is already asserted; reports what was observed.
    task automatic run_clear(input bit poke, output int busy_n, output int done_n,
                             output int rdy_n, output bit timed_out);
        step();
        clear_start = 1'b0;
        busy_n = 0; done_n = 0; rdy_n = 0; timed_out = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (!busy) begin
                timed_out = 1'b0;
                break;
            end
            busy_n++;
            if (clear_done) done_n++;
            if (wr_ready) rdy_n++;
            if (poke && c == 3) begin
                clear_start = 1'b1;
                clear_color = 8'h99;
            end else begin
                clear_start = 1'b0;
            end
            step();
        end
        clear_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", clear_done); end
        n_vec++; if (clip_cnt !== 16'h0) begin n_err++; $display("FAIL reset_clip: got %h expected 0000", clip_cnt); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", wr_ready); end
        n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd: got %h expected 00", rd_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_clear(input logic [7:0] color, input bit poke, input string tag);
        int  busy_n, done_n, rdy_n;
        bit  tmo;
        logic [7:0] exp;
        // Clear request collides with an off-frame write; accepting it would bump clip_cnt.
        clear_start = 1'b1;
        clear_color = color;
        wr_valid = 1'b1; wr_x = 3'd4; wr_y = 2'd0; wr_data = 8'hFF;
        #1;
        n_vec++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL %s_ready_at_start: got %b expected 0", tag, wr_ready); end
        run_clear(poke, busy_n, done_n, rdy_n, tmo);
        wr_valid = 1'b0;
        n_vec++; if (tmo !== 1'b0) begin n_err++; $display("FAIL %s_timeout: busy stuck, got %b expected 0", tag, tmo); end
        n_vec++; if (busy_n != 12) begin n_err++; $display("FAIL %s_busy_cycles: got %0d expected 12", tag, busy_n); end
        n_vec++; if (done_n != 1) begin n_err++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_n); end
        n_vec++; if (rdy_n != 0) begin n_err++; $display("FAIL %s_ready_in_clear: got %0d cycles expected 0", tag, rdy_n); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_after: got %b expected 1", tag, wr_ready); end
        n_vec++; if (clip_cnt !== exp_clip) begin n_err++; $display("FAIL %s_clip: got %h expected %h", tag, clip_cnt, exp_clip); end
        for (int i = 0; i < 12; i++) model[i] = color;
        for (int i = 0; i < 12; i++) begin
            issue_read(i % 4, i / 4);
            step();
            exp = sb_q.pop_front();
            n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL %s_rd%0d: got %h expected %h", tag, i, rd_data, exp); end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] exp;
        wr_valid = 1'b1; wr_x = 3'd2; wr_y = 2'd1; wr_data = 8'hA5;
        #1;
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready: got %b expected 1", wr_ready); end
        step();
        model[6] = 8'hA5;
        wr_valid = 1'b0;
        issue_read(2, 1);
        step();
        exp = sb_q.pop_front();
        n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL wr_then_rd: got %h expected %h", rd_data, exp); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL wr_ready_idle: got %b expected 1", wr_ready); end
        // Same-address read and write in one cycle: old data first, new data next.
        wr_valid = 1'b1; wr_data = 8'h5B;
        issue_read(2, 1);
        step();
        model[6] = 8'h5B;
        wr_valid = 1'b0;
        exp = sb_q.pop_front();
        n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL rw_collide_old: got %h expected %h", rd_data, exp); end
        issue_read(2, 1);
        step();
        exp = sb_q.pop_front();
        n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL rw_collide_new: got %h expected %h", rd_data, exp); end
    endtask

    task automatic test_oob();
        logic [7:0] exp;
        issue_read(4, 0);
        step();
        exp = sb_q.pop_front();
        n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL oob_rd_x: got %h expected %h", rd_data, exp); end
        issue_read(0, 3);
        step();
        exp = sb_q.pop_front();
        n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL oob_rd_y: got %h expected %h", rd_data, exp); end
        issue_read(3, 2);
        step();
        exp = sb_q.pop_front();
        n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL last_pixel_rd: got %h expected %h", rd_data, exp); end
        wr_valid = 1'b1; wr_x = 3'd4; wr_y = 2'd0; wr_data = 8'hFF;
        #1;
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL oob_wr_ready: got %b expected 1", wr_ready); end
        step();
        wr_valid = 1'b0;
        if (CLIP_EN) exp_clip = exp_clip + 16'd1;
        n_vec++; if (clip_cnt !== exp_clip) begin n_err++; $display("FAIL oob_clip: got %h expected %h", clip_cnt, exp_clip); end
        for (int i = 0; i < 12; i++) begin
            issue_read(i % 4, i / 4);
            step();
            exp = sb_q.pop_front();
            n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL oob_keep_rd%0d: got %h expected %h", i, rd_data, exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        int         not_ready = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            wr_x = 3'(i % 4);
            wr_y = 2'(i / 4);
            wr_data = 8'(8'h20 + i * 7);
            #1;
            if (wr_ready !== 1'b1) not_ready++;
            step();
            model[i] = 8'(8'h20 + i * 7);
        end
        wr_valid = 1'b0;
        n_vec++; if (not_ready != 0) begin n_err++; $display("FAIL b2b_ready: got %0d stalls expected 0", not_ready); end
        for (int i = 11; i >= 0; i--) begin
            issue_read(i % 4, i / 4);
            step();
            exp = sb_q.pop_front();
            n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL b2b_rd%0d: got %h expected %h", i, rd_data, exp); end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp;
        clear_start = 1'b1;
        clear_color = 8'h5A;
        step();
        clear_start = 1'b0;
        repeat (5) step();
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_vec++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b expected 1", wr_ready); end
        n_vec++; if (clip_cnt !== 16'h0) begin n_err++; $display("FAIL abort_clip: got %h expected 0000", clip_cnt); end
        n_vec++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL abort_rd: got %h expected 00", rd_data); end
        step();
        rst_n = 1'b1;
        exp_clip = '0;
        for (int i = 0; i < 5; i++) model[i] = 8'h5A;
        for (int i = 0; i < 12; i++) begin
            issue_read(i % 4, i / 4);
            step();
            exp = sb_q.pop_front();
            n_vec++; if (rd_data !== exp) begin n_err++; $display("FAIL abort_rd%0d: got %h expected %h", i, rd_data, exp); end
        end
    endtask

    task automatic test_clip_saturate();
        wr_valid = 1'b1; wr_x = 3'd5; wr_y = 2'd3; wr_data = 8'h00;
        repeat (65534) @(posedge clk);
        #1;
        exp_clip = CLIP_EN ? 16'hFFFE : 16'h0;
        n_vec++; if (clip_cnt !== exp_clip) begin n_err++; $display("FAIL clip_fffe: got %h expected %h", clip_cnt, exp_clip); end
        step();
        exp_clip = CLIP_EN ? 16'hFFFF : 16'h0;
        n_vec++; if (clip_cnt !== exp_clip) begin n_err++; $display("FAIL clip_ffff: got %h expected %h", clip_cnt, exp_clip); end
        step();
        step();
        wr_valid = 1'b0;
        n_vec++; if (clip_cnt !== exp_clip) begin n_err++; $display("FAIL clip_hold: got %h expected %h", clip_cnt, exp_clip); end
    endtask

    initial begin
        for (int i = 0; i < 12; i++) model[i] = 8'h00;
        test_reset();
        test_clear(8'h00, 1'b0, "clear_init");
        test_write_read();
        test_oob();
        test_clear(8'h11, 1'b1, "clear_11");
        test_back_to_back();
        test_reset_abort();
        test_clip_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
